reg_dump_unit: RTL and testbench
================================

# reg_dump_unit

Synthesizable register-file dump engine for the RV32 cores, both single-cycle and pipelined. It replaces hierarchical peeking into the register file at end of simulation. It sits beside the core's register file on a dedicated debug read port. On a trigger (explicit start, core halt, or cycle-count timeout) it scans all architectural registers and streams index/value pairs over a valid/ready interface to a bench monitor, UART bridge or trace sink.

## Interface
Parameters:
- XLEN, 32: register/data width
- NREGS, 32: number of registers scanned (x0..x(NREGS-1)); must be ≥ 2
- TIMEOUT, 500: cycles after reset release before an automatic dump; 0 disables auto-trigger
- IDXW, $clog2(NREGS+1): width of dump index

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a dump
- halt  in  1  core halted (ecall/ebreak); level, edge-detected internally
- rf_raddr  out  $clog2(NREGS)  debug read address into register file
- rf_rdata  in  XLEN  combinational read data for rf_raddr
- dump_valid  out  1  dump word valid
- dump_ready  in  1  sink accepts word
- dump_idx  out  IDXW  register index of current word
- dump_data  out  XLEN  register value (or checksum)
- dump_last  out  1  final word of this dump
- busy  out  1  dump in progress
- done  out  1  sticky: a dump completed
- cycle_count  out  32  cycles since reset release, saturating at 2^32-1

## Operation
- States: IDLE, READ, SEND, CSUM (only with checksum), DONE.
- Trigger = start | rising edge of halt | (TIMEOUT≠0 && cycle_count == TIMEOUT-1). Multiple triggers in the same cycle produce one dump.
- IDLE/DONE: a trigger clears idx to 0 and goes to READ. Triggers in READ/SEND/CSUM are ignored, with no queuing.
- READ: rf_raddr = idx. Capture rf_rdata into the data register, then go to SEND.
- SEND: dump_valid=1. dump_idx, dump_data and dump_last are held stable until dump_ready.
  - On handshake with idx < NREGS-1: idx++, go to READ.
  - On handshake with idx == NREGS-1: go to CSUM if enabled, else DONE.
- x0 is read through the port like any other register; the dump unit does not force it to zero.
- DONE: done=1, busy=0. done stays high until reset or the next trigger, which clears it in the cycle the dump restarts.
- busy=1 in READ, SEND and CSUM.
- cycle_count increments every cycle from reset release and saturates. The auto-trigger fires once only, because the compare is exact.
- rf_raddr holds the last idx when not in READ. It is never out of range.

## Timing
- Reset values:
  - state=IDLE
  - dump_valid=0, dump_last=0, busy=0, done=0
  - dump_idx=0, dump_data=0, rf_raddr=0
  - cycle_count=0
  - halt edge register=0, checksum=0
- Trigger in cycle N → READ in N+1 → dump_valid high in N+2.
- Throughput: one word per 2 cycles with dump_ready held high. A full 32-register dump takes 64 cycles, plus 1 for the checksum word when enabled.
- Backpressure: dump_ready low holds SEND indefinitely, and the outputs do not change.
- dump_valid never drops without a handshake, except on reset.
- Reset mid-dump aborts immediately to IDLE with the reset values above. The stream is truncated and dump_last is never seen.

## Configuration
- REG_DUMP_CHECKSUM_EN defined:
  - Accumulate the XOR of all NREGS values as they are captured; clear it on trigger.
  - After the last register, CSUM emits one extra word: dump_idx=NREGS, dump_data=checksum, dump_last=1.
  - The register word NREGS-1 then has dump_last=0.
- Not defined:
  - No CSUM state and no checksum register.
  - dump_last=1 on register NREGS-1.

## Structure
- Package reg_dump_pkg holds:
  - the state enum (IDLE, READ, SEND, CSUM, DONE)
  - the default XLEN/NREGS/TIMEOUT constants shared with the core parameters
- Sub-module reg_dump_timer contains:
  - the saturating cycle counter
  - the TIMEOUT compare that produces a one-cycle auto-trigger pulse
  - the halt edge detector
- The FSM and datapath live in reg_dump_unit.

## Test plan
- **Auto dump:** register file preloaded with x_i = i*3, TIMEOUT=500, dump_ready=1, checksum off.
  - Dump starts at cycle 500.
  - 32 words with idx 0..31 and data 0,3,…,93.
  - dump_last only on idx 31.
  - done rises 64 cycles after the trigger.
- **Backpressure:** start pulse with dump_ready toggling 1-in-3.
  - dump_idx and dump_data are stable while valid && !ready.
  - No word is lost or duplicated.
- **Retrigger ignored:** start and halt pulses issued mid-dump.
  - Exactly 32 words.
  - A later start in DONE clears done and produces a second full dump.
- **Reset mid-dump:** assert reset at word idx 10.
  - All outputs return to reset values asynchronously, before the next clock edge.
  - cycle_count restarts from 0.
- **Checksum (REG_DUMP_CHECKSUM_EN):** registers = 0xA5A5_0000 | i.
  - 33rd word has idx=32, data=0x0000_0000 (XOR of i for 0..31 is 0, and the pattern appears an even number of times).
  - dump_last only on that word.
- **TIMEOUT=0 with halt:** no auto dump ever occurs, and a halt rising edge starts the dump.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared defaults and FSM state type for the register-file dump engine.
// The CSUM state exists only when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

  localparam int unsigned XLEN_DEFAULT    = 32;
  localparam int unsigned NREGS_DEFAULT   = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 500;

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StRead, StSend, StCsum, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRead, StSend, StDone} state_e;
`endif

endpackage

// File: rtl/reg_dump_if.sv
// Valid/ready stream carrying one index/value pair per transfer.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned IDXW = $clog2(NREGS_DEFAULT + 1)
);

  logic            dump_valid;
  logic            dump_ready;
  logic [IDXW-1:0] dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_last;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/reg_dump_timer.sv
// Saturating cycle counter since reset release, one-shot timeout trigger
// and halt rising-edge detector.
module reg_dump_timer
  import reg_dump_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic [31:0] cycle_count,
  output logic        auto_trig,
  output logic        halt_rise
);

  logic halt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      halt_q      <= 1'b0;
    end else begin
      if (cycle_count != '1) begin
        cycle_count <= cycle_count + 32'd1;
      end
      halt_q <= halt;
    end
  end

  assign halt_rise = halt & ~halt_q;

  // Exact compare: once the counter moves past the match it can never recur.
  assign auto_trig = (TIMEOUT != 0) && (cycle_count == 32'(TIMEOUT - 1));

endmodule

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: on start, halt edge or timeout, streams x0..x(NREGS-1).
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word at index NREGS.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned NREGS   = NREGS_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned IDXW    = $clog2(NREGS + 1),
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  reg_dump_if.master      dump,
  output logic            busy,
  output logic            done,
  output logic [31:0]     cycle_count
);

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic            valid_q;
  logic            last_q;
  logic [IDXW-1:0] didx_q;
  logic [XLEN-1:0] data_q;
  logic            trigger;
  logic            auto_trig;
  logic            halt_rise;
  logic            at_last;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [XLEN-1:0] csum_q;
`endif

  reg_dump_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .cycle_count(cycle_count),
    .auto_trig  (auto_trig),
    .halt_rise  (halt_rise)
  );

  assign trigger  = start | halt_rise | auto_trig;
  assign at_last  = (idx_q == AW'(NREGS - 1));
  assign rf_raddr = idx_q;

  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = didx_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      didx_q  <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (trigger) begin
            state_q <= StRead;
            idx_q   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        StRead: begin
          data_q  <= rf_rdata;
          didx_q  <= IDXW'(idx_q);
          valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          last_q  <= 1'b0;
          csum_q  <= csum_q ^ rf_rdata;
`else
          last_q  <= at_last;
`endif
          state_q <= StSend;
        end
        StSend: begin
          if (dump.dump_ready) begin
            if (!at_last) begin
              valid_q <= 1'b0;
              idx_q   <= idx_q + AW'(1);
              state_q <= StRead;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Valid stays high: the checksum word follows back-to-back.
              didx_q  <= IDXW'(NREGS);
              data_q  <= csum_q;
              last_q  <= 1'b1;
              state_q <= StCsum;
`else
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        StCsum: begin
          if (dump.dump_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: expected words are queued at trigger time
// and popped by a negedge monitor on every handshake.
module tb_reg_dump_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned TIMEOUT = 500;
  localparam int unsigned IDXW    = $clog2(NREGS + 1);
  localparam int unsigned AW      = $clog2(NREGS);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int unsigned NWORDS = NREGS + (CS ? 1 : 0);

  typedef struct {
    int unsigned     idx;
    logic [XLEN-1:0] data;
    bit              last;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic halt2 = 1'b0;
  logic rdy = 1'b1;
  logic bp_mode = 1'b0;

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rf_raddr, rf_raddr2;
  logic [XLEN-1:0] rf_rdata, rf_rdata2;
  logic            busy, done, busy2, done2;
  logic [31:0]     cycle_count, cycle_count2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_words2 = 0;
  word_t       exp_q[$];

  logic            hold_v = 1'b0;
  logic [IDXW-1:0] hold_idx;
  logic [XLEN-1:0] hold_data;

  reg_dump_if #(.XLEN(XLEN), .IDXW(IDXW)) dif ();
  reg_dump_if #(.XLEN(XLEN), .IDXW(IDXW)) dif2 ();

  assign rf_rdata        = regs[rf_raddr];
  assign rf_rdata2       = regs[rf_raddr2];
  assign dif.dump_ready  = rdy;
  assign dif2.dump_ready = 1'b1;

  reg_dump_unit #(.XLEN(XLEN), .NREGS(NREGS), .TIMEOUT(TIMEOUT), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump(dif),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  reg_dump_unit #(.XLEN(XLEN), .NREGS(NREGS), .TIMEOUT(0), .IDXW(IDXW)) dut2 (
    .clk(clk), .reset(reset), .start(1'b0), .halt(halt2),
    .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .dump(dif2),
    .busy(busy2), .done(done2), .cycle_count(cycle_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [XLEN-1:0] xor_all();
    logic [XLEN-1:0] x = '0;
    for (int i = 0; i < NREGS; i++) x ^= regs[i];
    return x;
  endfunction

  // Reference: a dump is every register in index order, then optionally the XOR.
  task automatic push_dump();
    for (int i = 0; i < NREGS; i++) begin
      exp_q.push_back('{idx: i, data: regs[i], last: (i == NREGS - 1) && !CS});
    end
    if (CS) exp_q.push_back('{idx: NREGS, data: xor_all(), last: 1'b1});
  endtask

  task automatic check_reset_vals();
    check("reset dump_valid", dif.dump_valid, 0);
    check("reset dump_last", dif.dump_last, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dump_idx", dif.dump_idx, 0);
    check("reset dump_data", dif.dump_data, 0);
    check("reset rf_raddr", rf_raddr, 0);
    check("reset cycle_count", cycle_count, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("dump completes within budget", done, 1);
    check("all expected words delivered", exp_q.size(), 0);
  endtask

  // Main scoreboard monitor plus stall-stability check.
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("valid held under stall", dif.dump_valid, 1);
        check("idx held under stall", dif.dump_idx, hold_idx);
        check("data held under stall", dif.dump_data, hold_data);
      end
      hold_v    = dif.dump_valid && !rdy;
      hold_idx  = dif.dump_idx;
      hold_data = dif.dump_data;
      if (dif.dump_valid && rdy) begin
        check("word expected by scoreboard", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("dump_idx", dif.dump_idx, e.idx);
          check("dump_data", dif.dump_data, e.data);
          check("dump_last", dif.dump_last, e.last);
        end
      end
    end
  end

  // Second unit (auto-trigger disabled) always accepts; check words against the array.
  always @(negedge clk) begin
    if (!reset && dif2.dump_valid) begin
      if (dif2.dump_idx < NREGS) check("dut2 data", dif2.dump_data, regs[dif2.dump_idx[AW-1:0]]);
      else check("dut2 checksum", dif2.dump_data, xor_all());
      n_words2++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rdy = bp_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Auto dump at TIMEOUT with x_i = i*3
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    push_dump();
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 700 && !dif.dump_valid; i++) @(negedge clk);
    check("auto dump first valid cycle", cycle_count, TIMEOUT + 1);
    wait_done(200);
    check("auto dump done cycle", cycle_count, TIMEOUT + 64);
    check("dut2 no auto dump busy", busy2, 0);
    check("dut2 no auto dump done", done2, 0);
    check("dut2 no words yet", n_words2, 0);

    // Backpressure with random data
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    bp_mode = 1'b1;
    push_dump();
    pulse_start();
    wait_done(3000);
    bp_mode = 1'b0;

    // Retriggers mid-dump are ignored; start in DONE restarts
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    push_dump();
    pulse_start();
    repeat (15) @(posedge clk);
    #1 start = 1'b1; halt = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 halt = 1'b0;
    wait_done(200);
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    push_dump();
    pulse_start();
    check("done cleared on restart", done, 0);
    check("busy on restart", busy, 1);
    wait_done(200);

    // Checksum pattern
    for (int i = 0; i < NREGS; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
    push_dump();
    pulse_start();
    wait_done(200);

    // TIMEOUT=0 unit dumps on halt rising edge
    check("dut2 idle before halt", busy2 | done2, 0);
    @(posedge clk); #1 halt2 = 1'b1;
    for (int i = 0; i < 200 && !done2; i++) @(negedge clk);
    check("dut2 halt dump done", done2, 1);
    check("dut2 word count", n_words2, NWORDS);
    halt2 = 1'b0;

    // Reset mid-dump at word 10
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    push_dump();
    pulse_start();
    for (int i = 0; i < 100 && !(dif.dump_valid && dif.dump_idx == 10); i++) @(negedge clk);
    check("reached word 10", dif.dump_idx, 10);
    #2 reset = 1'b1;
    #1 check_reset_vals();
    exp_q.delete();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cycle_count restarts", cycle_count, 3);
    check("idle after reset", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
